// File: rtl/fft_r2sdf_pkg.sv
// -----------------------------------------------------------------------------
// fft_r2sdf_pkg
// Shared constants and types for the radix-2 single-delay-feedback FFT stages.
//   SAMPLE_DW   : default width of each real/imag sample (two's complement)
//   CNT_W       : width of the per-frame sample counter of the span-4 stage
//   SPAN_STAGE4 : delay-line depth (butterfly span) of the 8-point stage
//   phase_e     : Fill / Bfly phase, taken from the counter MSB
// Complex samples are packed {Re, Im}, with Re in the MSBs.
// -----------------------------------------------------------------------------
package fft_r2sdf_pkg;

    localparam int SAMPLE_DW   = 36;
    localparam int CNT_W       = 3;
    localparam int SPAN_STAGE4 = 4;

    // Phase of the current frame position: the first half of every 8-sample
    // frame fills the delay line, the second half runs the butterfly.
    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_e;

endpackage

// File: rtl/r2sdf_delay4.sv
// -----------------------------------------------------------------------------
// r2sdf_delay4
// Complex shift register used as the feedback delay of a single-delay-feedback
// butterfly stage. Shifts one position per enabled clock; the output is the
// entry written DEPTH enabled clocks ago. Contents are deliberately not reset:
// the stage above guarantees stale entries never reach a valid output.
// Ports:
//   iClk   in  1  rising-edge clock
//   iEn    in  1  shift enable (one accepted sample)
//   iData  in  W  packed {Re, Im} entering the line
//   oData  out W  head of the line (oldest entry)
// -----------------------------------------------------------------------------
module r2sdf_delay4
    import fft_r2sdf_pkg::*;
#(
    parameter int W     = 2 * SAMPLE_DW,
    parameter int DEPTH = SPAN_STAGE4
) (
    input  logic         iClk,
    input  logic         iEn,
    input  logic [W-1:0] iData,
    output logic [W-1:0] oData
);

    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] sr_d [DEPTH];

    always_comb begin
        sr_d[0] = iData;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge iClk) begin
        if (iEn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    assign oData = sr_q[DEPTH-1];

endmodule

// File: rtl/r2sdf_bf_stage4.sv
// -----------------------------------------------------------------------------
// r2sdf_bf_stage4
// Radix-2 single-delay-feedback butterfly stage with span 4 (the 8-point stage
// of an R2SDF FFT). Owns a 4-deep complex feedback delay line and the add/sub
// butterfly. Output is natural-order pass-through into the next twiddle
// multiplier; oIdx tells that multiplier the twiddle index of each sample.
// Parameters:
//   DW     sample width of each real/imag part
//   SCALE  1: sum/diff formed at DW+1 bits then >>>1 (floor); 0: wrap mod 2^DW
// Ports:
//   iClk      in   1   rising-edge clock
//   iRst_n    in   1   asynchronous active-low reset
//   iEn       in   1   global stage enable
//   iValid    in   1   input sample present
//   iData_Re  in   DW  input real part
//   iData_Im  in   DW  input imaginary part
//   oData_Re  out  DW  registered output real part
//   oData_Im  out  DW  registered output imaginary part
//   oValid    out  1   oData/oIdx valid this cycle
//   oIdx      out  3   position of the output sample within its 8-sample frame
//
// Flow control: there is no back-pressure. A sample is accepted in any cycle
// where acc = iEn & iValid; only an accepted sample advances the counter, the
// delay line, primed and the output data. oValid is a one-cycle strobe for the
// sample accepted on the previous edge and is 0 in every non-accepting cycle.
// -----------------------------------------------------------------------------
module r2sdf_bf_stage4
    import fft_r2sdf_pkg::*;
#(
    parameter int DW    = SAMPLE_DW,
    parameter int SCALE = 0
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iEn,
    input  logic          iValid,
    input  logic [DW-1:0] iData_Re,
    input  logic [DW-1:0] iData_Im,
    output logic [DW-1:0] oData_Re,
    output logic [DW-1:0] oData_Im,
    output logic          oValid,
    output logic [2:0]    oIdx
);

    localparam int CW = 2 * DW;

    // Butterfly add/sub: formed one bit wider so SCALE=1 can floor-halve
    // without overflow; SCALE=0 keeps the low DW bits (wrap-around).
    function automatic logic [DW-1:0] bf_add(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW:0] full;
        full = {a[DW-1], a} + {b[DW-1], b};
        if (SCALE != 0) begin
            return full[DW:1];
        end
        return full[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] bf_sub(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW:0] full;
        full = {a[DW-1], a} - {b[DW-1], b};
        if (SCALE != 0) begin
            return full[DW:1];
        end
        return full[DW-1:0];
    endfunction

    logic             acc;
    phase_e           phase;

    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             primed_q,    primed_d;
    logic [DW-1:0]    out_re_q,    out_re_d;
    logic [DW-1:0]    out_im_q,    out_im_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       out_idx_q,   out_idx_d;

    logic [CW-1:0]    dl_in;
    logic [CW-1:0]    dl_head;
    logic [DW-1:0]    b_re, b_im;
    logic [DW-1:0]    sum_re, sum_im;
    logic [DW-1:0]    diff_re, diff_im;
    logic [DW-1:0]    cand_re, cand_im;
    logic [DW-1:0]    dl_in_re, dl_in_im;

    assign acc   = iEn & iValid;
    assign phase = phase_e'(cnt_q[CNT_W-1]);

    // Head of the feedback line: the entry written SPAN_STAGE4 accepts ago.
    assign b_re = dl_head[CW-1:DW];
    assign b_im = dl_head[DW-1:0];

    assign sum_re  = bf_add(b_re, iData_Re);
    assign sum_im  = bf_add(b_im, iData_Im);
    assign diff_re = bf_sub(b_re, iData_Re);
    assign diff_im = bf_sub(b_im, iData_Im);

    // Fill: park x in the line and emit the difference left over from the
    // previous frame. Bfly: emit the sum and park the difference for later.
    always_comb begin
        cand_re  = b_re;
        cand_im  = b_im;
        dl_in_re = iData_Re;
        dl_in_im = iData_Im;
        if (phase == PH_BFLY) begin
            cand_re  = sum_re;
            cand_im  = sum_im;
            dl_in_re = diff_re;
            dl_in_im = diff_im;
        end
    end

    assign dl_in = {dl_in_re, dl_in_im};

    r2sdf_delay4 #(
        .W     (CW),
        .DEPTH (SPAN_STAGE4)
    ) u_delay (
        .iClk  (iClk),
        .iEn   (acc),
        .iData (dl_in),
        .oData (dl_head)
    );

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        out_valid_d = 1'b0;
        if (acc) begin
            cnt_d     = cnt_q + CNT_W'(1);
            // Once a whole frame has gone through, the line holds real
            // differences and Fill-phase outputs become meaningful.
            primed_d  = primed_q | (cnt_q == {CNT_W{1'b1}});
            out_re_d  = cand_re;
            out_im_d  = cand_im;
            // Bfly outputs are the upper half (index 0..3, unit twiddle);
            // Fill outputs are the lower half (index 4..7, twiddled).
            out_idx_d = {~cnt_q[CNT_W-1], cnt_q[1:0]};
            out_valid_d = cnt_q[CNT_W-1] | primed_q;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign oData_Re = out_re_q;
    assign oData_Im = out_im_q;
    assign oValid   = out_valid_q;
    assign oIdx     = out_idx_q;

endmodule

// File: tb/tb_r2sdf_bf_stage4.sv
// -----------------------------------------------------------------------------
// tb_r2sdf_bf_stage4
// Bench for r2sdf_bf_stage4. Two instances share the input stream: dut0 with
// SCALE=0 (wrap) and dut1 with SCALE=1 (halve). A frame-level reference model
// computes each output from the accepted samples of the current and previous
// 8-sample frame and pushes {known, valid, idx, re, im} per instance into
// exp_q; each test task pops and compares after every clock.
// -----------------------------------------------------------------------------
module tb_r2sdf_bf_stage4;

  localparam int DW = 36;
  localparam int RW = 2 + 3 + 2 * DW;   // {known, valid, idx[2:0], re, im}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic          i_en    = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_re    = '0;
  logic [DW-1:0] i_im    = '0;

  logic [DW-1:0] o_re0, o_im0, o_re1, o_im1;
  logic          o_v0, o_v1;
  logic [2:0]    o_idx0, o_idx1;

  r2sdf_bf_stage4 #(.DW(DW), .SCALE(0)) dut0 (
    .iClk(clk), .iRst_n(rst_n), .iEn(i_en), .iValid(i_valid),
    .iData_Re(i_re), .iData_Im(i_im),
    .oData_Re(o_re0), .oData_Im(o_im0), .oValid(o_v0), .oIdx(o_idx0)
  );

  r2sdf_bf_stage4 #(.DW(DW), .SCALE(1)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iEn(i_en), .iValid(i_valid),
    .iData_Re(i_re), .iData_Im(i_im),
    .oData_Re(o_re1), .oData_Im(o_im1), .oValid(o_v1), .oIdx(o_idx1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  logic          obs_v   [2];
  logic [2:0]    obs_idx [2];
  logic [DW-1:0] obs_re  [2];
  logic [DW-1:0] obs_im  [2];

  // ---------------- reference model ----------------
  int            m_pos;
  bit            m_have_prev;
  longint        cur_re[8], cur_im[8], prev_re[8], prev_im[8];
  logic [DW-1:0] last_re[2], last_im[2];
  logic [2:0]    last_idx[2];
  bit            last_known[2];

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // s=0: wrap to DW bits; s=1: floor-halve the exact result.
  function automatic logic [DW-1:0] ref_add(input int s, input longint a, input longint b);
    longint t;
    t = a + b;
    if (s == 1) t = t >>> 1;
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_have_prev = 0;
    for (int s = 0; s < 2; s++) begin
      last_re[s] = '0;
      last_im[s] = '0;
      last_idx[s] = '0;
      last_known[s] = 1;
    end
    exp_q.delete();
  endtask

  // Frame view: positions 0..3 of a frame emit (a[p] - a[p+4]) of the previous
  // frame, positions 4..7 emit a[p-4] + a[p] of the current frame.
  task automatic model_step(input logic acc, input logic [DW-1:0] re, input logic [DW-1:0] im);
    int p;
    logic v;
    for (int s = 0; s < 2; s++) begin
      v = 1'b0;
      if (acc) begin
        p = m_pos;
        if (p < 4) begin
          last_idx[s] = 3'(p + 4);
          v = m_have_prev;
          last_known[s] = m_have_prev;
          if (m_have_prev) begin
            last_re[s] = ref_add(s, prev_re[p], -prev_re[p+4]);
            last_im[s] = ref_add(s, prev_im[p], -prev_im[p+4]);
          end
        end else begin
          last_idx[s] = 3'(p - 4);
          v = 1'b1;
          last_known[s] = 1;
          last_re[s] = ref_add(s, cur_re[p-4], sx(re));
          last_im[s] = ref_add(s, cur_im[p-4], sx(im));
        end
      end
      exp_q.push_back({last_known[s], v, last_idx[s], last_re[s], last_im[s]});
    end
    if (acc) begin
      cur_re[m_pos] = sx(re);
      cur_im[m_pos] = sx(im);
      m_pos++;
      if (m_pos == 8) begin
        prev_re = cur_re;
        prev_im = cur_im;
        m_have_prev = 1;
        m_pos = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic vld, input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(negedge clk);
    i_en = en; i_valid = vld; i_re = re; i_im = im;
    @(posedge clk);
    #1;
    obs_v[0] = o_v0; obs_idx[0] = o_idx0; obs_re[0] = o_re0; obs_im[0] = o_im0;
    obs_v[1] = o_v1; obs_idx[1] = o_idx1; obs_re[1] = o_re1; obs_im[1] = o_im1;
    model_step(en & vld, re, im);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_en = 1'b0; i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({o_v0, o_idx0} !== 4'b0) begin errors++; $display("FAIL reset_ctl0: got valid=%b idx=%0d, want 0/0", o_v0, o_idx0); end
    checks++;
    if ({o_re0, o_im0} !== '0) begin errors++; $display("FAIL reset_data0: got re=%h im=%h, want 0", o_re0, o_im0); end
    checks++;
    if ({o_v1, o_idx1} !== 4'b0) begin errors++; $display("FAIL reset_ctl1: got valid=%b idx=%0d, want 0/0", o_v1, o_idx1); end
    checks++;
    if ({o_re1, o_im1} !== '0) begin errors++; $display("FAIL reset_data1: got re=%h im=%h, want 0", o_re1, o_im1); end
    rst_n = 1'b1;
    model_reset();
  endtask

  // mode 0: Re ramp; 1: Re ramp with bubbles; 2: Im ramp; 3: Re ramp, no reset first
  task automatic test_ramp(input int mode);
    int k;
    int n;
    logic [RW-1:0] rec;
    logic [DW-1:0] v, main_o, other_o;
    longint spec_val[8];
    spec_val = '{6, 8, 10, 12, -4, -4, -4, -4};
    if (mode != 3) apply_reset();
    k = 0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      v = (i < 8) ? DW'(i + 1) : '0;
      for (int b = 0; b < 2; b++) begin
        if (b == 0) step(1'b1, 1'b1, (mode == 2) ? '0 : v, (mode == 2) ? v : '0);
        else if (mode == 1 && (i == 1 || i == 5)) step(1'b1, 1'b0, DW'($urandom), DW'($urandom));
        else if (mode == 1 && i == 10) step(1'b0, 1'b1, DW'($urandom), DW'($urandom));
        else continue;
        n++;
        for (int s = 0; s < 2; s++) begin
          rec = exp_q.pop_front();
          checks++;
          if ({obs_v[s], obs_idx[s]} !== rec[RW-2 -: 4]) begin
            errors++;
            $display("FAIL ramp%0d_ctl dut%0d cyc %0d: got valid=%b idx=%0d, want valid=%b idx=%0d",
                     mode, s, n, obs_v[s], obs_idx[s], rec[RW-2], rec[RW-3 -: 3]);
          end
          if (rec[RW-1]) begin
            checks++;
            if ({obs_re[s], obs_im[s]} !== rec[2*DW-1:0]) begin
              errors++;
              $display("FAIL ramp%0d_data dut%0d cyc %0d: got re=%h im=%h, want re=%h im=%h",
                       mode, s, n, obs_re[s], obs_im[s], rec[2*DW-1 -: DW], rec[DW-1:0]);
            end
          end
        end
        if (obs_v[0]) begin
          main_o  = (mode == 2) ? obs_im[0] : obs_re[0];
          other_o = (mode == 2) ? obs_re[0] : obs_im[0];
          if (k < 8) begin
            checks++;
            if (main_o !== DW'(spec_val[k]) || other_o !== '0 || obs_idx[0] !== 3'(k)) begin
              errors++;
              $display("FAIL ramp%0d_spec out %0d: got val=%h other=%h idx=%0d, want val=%h other=0 idx=%0d",
                       mode, k, main_o, other_o, obs_idx[0], DW'(spec_val[k]), k);
            end
          end
          k++;
        end
      end
    end
    checks++;
    if (k != 12) begin errors++; $display("FAIL ramp%0d_count: got %0d valid outputs, want 12", mode, k); end
  endtask

  task automatic test_async_reset();
    logic [RW-1:0] rec;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, DW'(i + 1), '0);
      for (int s = 0; s < 2; s++) begin
        rec = exp_q.pop_front();
        checks++;
        if ({obs_v[s], obs_idx[s]} !== rec[RW-2 -: 4]) begin
          errors++;
          $display("FAIL areset_pre_ctl dut%0d step %0d: got valid=%b idx=%0d, want valid=%b idx=%0d",
                   s, i, obs_v[s], obs_idx[s], rec[RW-2], rec[RW-3 -: 3]);
        end
        if (rec[RW-1]) begin
          checks++;
          if ({obs_re[s], obs_im[s]} !== rec[2*DW-1:0]) begin
            errors++;
            $display("FAIL areset_pre_data dut%0d step %0d: got re=%h, want re=%h", s, i, obs_re[s], rec[2*DW-1 -: DW]);
          end
        end
      end
    end
    // Assert reset away from any clock edge; outputs must clear at once.
    @(negedge clk);
    i_en = 1'b0; i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_v0, o_idx0, o_re0, o_im0} !== '0) begin
      errors++; $display("FAIL areset_clear0: got valid=%b idx=%0d re=%h im=%h, want all 0", o_v0, o_idx0, o_re0, o_im0);
    end
    checks++;
    if ({o_v1, o_idx1, o_re1, o_im1} !== '0) begin
      errors++; $display("FAIL areset_clear1: got valid=%b idx=%0d re=%h im=%h, want all 0", o_v1, o_idx1, o_re1, o_im1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    test_ramp(3);
  endtask

  task automatic test_wrap();
    logic [RW-1:0] rec;
    logic [DW-1:0] a;
    logic [DW-1:0] x;
    logic [DW-1:0] want0, want1;
    logic [DW-1:0] big;
    big = 36'h7_FFFF_FFFF;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      a = (i == 0) ? big : ((i == 4) ? 36'd1 : '0);
      x = a;
      step(1'b1, 1'b1, a, x);
      for (int s = 0; s < 2; s++) begin
        rec = exp_q.pop_front();
        checks++;
        if ({obs_v[s], obs_idx[s]} !== rec[RW-2 -: 4]) begin
          errors++;
          $display("FAIL wrap_ctl dut%0d step %0d: got valid=%b idx=%0d, want valid=%b idx=%0d",
                   s, i, obs_v[s], obs_idx[s], rec[RW-2], rec[RW-3 -: 3]);
        end
        if (rec[RW-1]) begin
          checks++;
          if ({obs_re[s], obs_im[s]} !== rec[2*DW-1:0]) begin
            errors++;
            $display("FAIL wrap_data dut%0d step %0d: got re=%h im=%h, want re=%h im=%h",
                     s, i, obs_re[s], obs_im[s], rec[2*DW-1 -: DW], rec[DW-1:0]);
          end
        end
      end
      if (i == 4 || i == 8) begin
        want0 = (i == 4) ? 36'h8_0000_0000 : 36'h7_FFFF_FFFE;
        want1 = (i == 4) ? 36'h4_0000_0000 : 36'h3_FFFF_FFFF;
        checks++;
        if (obs_v[0] !== 1'b1 || obs_re[0] !== want0) begin
          errors++; $display("FAIL wrap_scale0 step %0d: got valid=%b re=%h, want valid=1 re=%h", i, obs_v[0], obs_re[0], want0);
        end
        checks++;
        if (obs_v[1] !== 1'b1 || obs_re[1] !== want1) begin
          errors++; $display("FAIL wrap_scale1 step %0d: got valid=%b re=%h, want valid=1 re=%h", i, obs_v[1], obs_re[1], want1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] rec;
    logic [DW-1:0] re, im;
    logic en, vld;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      vld = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       re = 36'h7_FFFF_FFFF;
        1:       re = 36'h8_0000_0000;
        default: re = {$urandom_range(0, 15), $urandom()};
      endcase
      im = ($urandom_range(0, 5) == 0) ? 36'h8_0000_0000 : {$urandom_range(0, 15), $urandom()};
      step(en, vld, re, im);
      for (int s = 0; s < 2; s++) begin
        rec = exp_q.pop_front();
        checks++;
        if ({obs_v[s], obs_idx[s]} !== rec[RW-2 -: 4]) begin
          errors++;
          $display("FAIL rand_ctl dut%0d step %0d: got valid=%b idx=%0d, want valid=%b idx=%0d",
                   s, i, obs_v[s], obs_idx[s], rec[RW-2], rec[RW-3 -: 3]);
        end
        if (rec[RW-1]) begin
          checks++;
          if ({obs_re[s], obs_im[s]} !== rec[2*DW-1:0]) begin
            errors++;
            $display("FAIL rand_data dut%0d step %0d: got re=%h im=%h, want re=%h im=%h",
                     s, i, obs_re[s], obs_im[s], rec[2*DW-1 -: DW], rec[DW-1:0]);
          end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_ramp(0);
    test_ramp(1);
    test_wrap();
    test_async_reset();
    test_ramp(2);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
